// File: rtl/double_dabble_bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter using the shift-and-add-3
// (double dabble) algorithm, one bit per clock, result presented with a valid pulse.
module double_dabble_bcd (
    input  logic       CLKK,
    input  logic       RST,
    input  logic       start,
    input  logic [7:0] binIN,
    output logic       busy,
    output logic       valid,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [11:0] scratch_q, scratch_d;
    logic [2:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [3:0]  hundreds_q, hundreds_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic [11:0] corr;

    // Every nibble is judged on its pre-step value, so corrections never interact.
    function automatic logic [11:0] add3(input logic [11:0] s);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = (s[i*4 +: 4] >= 4'd5) ? s[i*4 +: 4] + 4'd3 : s[i*4 +: 4];
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        count_d    = count_q;
        hundreds_d = hundreds_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        valid_d    = 1'b0;
        corr       = add3(scratch_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = binIN;
                    scratch_d = 12'd0;
                    count_d   = 3'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, shreg_d} = {corr, shreg_q} << 1;
                count_d = count_q + 3'd1;
                if (count_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                hundreds_d = scratch_q[11:8];
                tens_d     = scratch_q[7:4];
                ones_d     = scratch_q[3:0];
                valid_d    = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // busy is registered from the next state so it tracks state_q exactly.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLKK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            shreg_q    <= 8'd0;
            scratch_q  <= 12'd0;
            count_q    <= 3'd0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            hundreds_q <= 4'd0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            hundreds_q <= hundreds_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign hundreds = hundreds_q;
    assign tens     = tens_q;
    assign ones     = ones_q;

endmodule
